// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives columns one at a time (active-low), samples
// active-low rows, and debounces whole scan frames into single key events.
module keypad_scan #(
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk_div,
    input  logic       reset,
    input  logic [3:0] keypad_row,
    output logic [3:0] keypad_col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] N_FRAMES = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [1:0]       r_col_idx;
    logic [3:0]       r_col_drive;
    logic             r_hit;
    logic [3:0]       r_cand;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_stored;
    logic [3:0]       r_code;
    logic             r_valid;
    logic             r_held;

    logic             w_row_hit;
    logic [1:0]       w_row_sel;
    logic             w_frame_end;
    logic             w_frame_hit;
    logic [3:0]       w_frame_cand;
    logic [1:0]       w_col_next;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [3:0]       w_stored_nxt;
    logic [3:0]       w_code_nxt;
    logic             w_pulse;

    assign keypad_col = r_col_drive;
    assign key_valid  = r_valid;
    assign key_code   = r_code;
    assign key_held   = r_held;

    assign w_frame_end = (r_col_idx == 2'd3);
    assign w_col_next  = r_col_idx + 2'd1;
    assign w_row_hit   = (keypad_row != 4'b1111);
    assign w_cnt_inc   = r_cnt + CNT_ONE;
    // A hit already latched this frame outranks the current column's sample.
    assign w_frame_hit  = r_hit | w_row_hit;
    assign w_frame_cand = r_hit ? r_cand : {w_row_sel, r_col_idx};

    // Lowest-numbered low row in the column currently driven.
    always_comb begin
        w_row_sel = 2'd0;
        if (!keypad_row[0]) begin
            w_row_sel = 2'd0;
        end else if (!keypad_row[1]) begin
            w_row_sel = 2'd1;
        end else if (!keypad_row[2]) begin
            w_row_sel = 2'd2;
        end else if (!keypad_row[3]) begin
            w_row_sel = 2'd3;
        end else begin
            w_row_sel = 2'd0;
        end
    end

    // Column counter and registered active-low column drive.
    always_ff @(posedge clk_div or negedge reset) begin
        if (!reset) begin
            r_col_idx   <= 2'd0;
            r_col_drive <= 4'b0111;
        end else begin
            r_col_idx   <= w_col_next;
            r_col_drive <= ~(4'b1000 >> w_col_next);
        end
    end

    // Per-frame candidate: first hit in scan order, cleared at frame end.
    always_ff @(posedge clk_div or negedge reset) begin
        if (!reset) begin
            r_hit  <= 1'b0;
            r_cand <= 4'd0;
        end else if (w_frame_end) begin
            r_hit  <= 1'b0;
            r_cand <= 4'd0;
        end else if (!r_hit && w_row_hit) begin
            r_hit  <= 1'b1;
            r_cand <= {w_row_sel, r_col_idx};
        end else begin
            r_hit  <= r_hit;
            r_cand <= r_cand;
        end
    end

    // Debounce next-state; only a frame-end edge can move the FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stored_nxt = r_stored;
        w_code_nxt   = r_code;
        w_pulse      = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                IDLE: begin
                    if (w_frame_hit) begin
                        w_stored_nxt = w_frame_cand;
                        if (N_FRAMES == CNT_ONE) begin
                            w_state_nxt = HELD;
                            w_cnt_nxt   = CNT_ZERO;
                            w_code_nxt  = w_frame_cand;
                            w_pulse     = 1'b1;
                        end else begin
                            w_state_nxt = PRESS_DB;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end else begin
                        w_cnt_nxt = CNT_ZERO;
                    end
                end
                PRESS_DB: begin
                    if (!w_frame_hit) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = CNT_ZERO;
                    end else if (w_frame_cand != r_stored) begin
                        w_stored_nxt = w_frame_cand;
                        w_cnt_nxt    = CNT_ONE;
                    end else if (w_cnt_inc == N_FRAMES) begin
                        w_state_nxt = HELD;
                        w_cnt_nxt   = CNT_ZERO;
                        w_code_nxt  = r_stored;
                        w_pulse     = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                HELD: begin
                    if (w_frame_hit) begin
                        w_state_nxt = HELD;
                    end else if (N_FRAMES == CNT_ONE) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_state_nxt = REL_DB;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                REL_DB: begin
                    if (w_frame_hit) begin
                        w_state_nxt = HELD;
                        w_cnt_nxt   = CNT_ZERO;
                    end else if (w_cnt_inc == N_FRAMES) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Debounce state and registered key outputs.
    always_ff @(posedge clk_div or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= CNT_ZERO;
            r_stored <= 4'd0;
            r_code   <= 4'd0;
            r_valid  <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stored <= w_stored_nxt;
            r_code   <= w_code_nxt;
            r_valid  <= w_pulse;
            r_held   <= (w_state_nxt == HELD) || (w_state_nxt == REL_DB);
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a behavioural keypad matrix answers the column
// drive, and each vector is compared against hand-computed expectations.
module tb_keypad_scan;

    logic       clk_div;
    logic       reset;
    logic [3:0] keypad_row;
    logic [3:0] keypad_col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    logic [15:0] keys;   // bit {row,col} set = that key is physically down
    int n_vec;
    int n_err;

    keypad_scan #(.DEBOUNCE_FRAMES(4), .CNT_W(3)) dut (
        .clk_div    (clk_div),
        .reset      (reset),
        .keypad_row (keypad_row),
        .keypad_col (keypad_col),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_held   (key_held)
    );

    initial clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    // Keypad matrix: a down key pulls its row low while its column is driven low.
    always_comb begin
        keypad_row = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (keypad_col[3-c] == 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[r*4+c]) keypad_row[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_div);
        #1;
    endtask

    // Four edges; key_valid must be high only after the frame-end edge when asked.
    task automatic frame(input string tag, input bit exp_pulse);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk(tag, {7'd0, key_valid}, {7'd0, (i == 3) && exp_pulse});
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_col"},   {4'd0, keypad_col}, 8'h07);
        chk({tag, "_valid"}, {7'd0, key_valid},  8'h00);
        chk({tag, "_held"},  {7'd0, key_held},   8'h00);
        chk({tag, "_code"},  {4'd0, key_code},   8'h00);
    endtask

    initial begin
        logic [3:0] col_seq [4];
        col_seq[0] = 4'b1011;
        col_seq[1] = 4'b1101;
        col_seq[2] = 4'b1110;
        col_seq[3] = 4'b0111;
        n_vec = 0;
        n_err = 0;
        keys  = 16'h0000;
        reset = 1'b0;
        #12;
        reset_checks("rst");

        // Idle scan
        @(negedge clk_div);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("scan_col", {4'd0, keypad_col}, {4'd0, col_seq[i%4]});
            chk("scan_valid", {7'd0, key_valid}, 8'h00);
            chk("scan_held", {7'd0, key_held}, 8'h00);
        end

        // Key (2,1) down from reset release: pulse after edge 16
        @(negedge clk_div);
        reset = 1'b0;
        keys  = 16'h0200;
        #1;
        reset_checks("rst2");
        @(negedge clk_div);
        reset = 1'b1;
        for (int f = 0; f < 3; f++) frame("lat_nopulse", 1'b0);
        frame("lat_pulse", 1'b1);
        chk("lat_code", {4'd0, key_code}, 8'h09);
        chk("lat_held", {7'd0, key_held}, 8'h01);

        // Short release then re-press: no new event
        keys = 16'h0000;
        frame("rel2", 1'b0);
        frame("rel2", 1'b0);
        chk("rel2_held", {7'd0, key_held}, 8'h01);
        keys = 16'h0200;
        frame("repress", 1'b0);
        chk("repress_held", {7'd0, key_held}, 8'h01);
        keys = 16'h0000;
        for (int f = 0; f < 3; f++) frame("rel4", 1'b0);
        chk("rel3_held", {7'd0, key_held}, 8'h01);
        frame("rel4", 1'b0);
        chk("rel4_held", {7'd0, key_held}, 8'h00);
        keys = 16'h8000;
        for (int f = 0; f < 3; f++) frame("k33_nopulse", 1'b0);
        frame("k33_pulse", 1'b1);
        chk("k33_code", {4'd0, key_code}, 8'h0F);
        chk("k33_held", {7'd0, key_held}, 8'h01);
        keys = 16'h0000;
        for (int f = 0; f < 4; f++) frame("k33_rel", 1'b0);
        chk("k33_rel_held", {7'd0, key_held}, 8'h00);

        // Bounce: on 2, off 1, on 4 -> single pulse at frame 7
        keys = 16'h0004;
        frame("bounce", 1'b0);
        frame("bounce", 1'b0);
        keys = 16'h0000;
        frame("bounce", 1'b0);
        chk("bounce_held", {7'd0, key_held}, 8'h00);
        keys = 16'h0004;
        for (int f = 0; f < 3; f++) frame("bounce", 1'b0);
        frame("bounce_pulse", 1'b1);
        chk("bounce_code", {4'd0, key_code}, 8'h02);
        keys = 16'h0000;
        for (int f = 0; f < 4; f++) frame("bounce_rel", 1'b0);

        // Two keys (0,3) and (1,0): column 0 is scanned first
        keys = 16'h0018;
        for (int f = 0; f < 3; f++) frame("multi", 1'b0);
        frame("multi_pulse", 1'b1);
        chk("multi_code", {4'd0, key_code}, 8'h04);
        keys = 16'h0000;
        for (int f = 0; f < 4; f++) frame("multi_rel", 1'b0);
        chk("multi_rel_held", {7'd0, key_held}, 8'h00);

        // Reset during PRESS_DB with cnt=3, key kept down
        keys = 16'h0200;
        for (int f = 0; f < 3; f++) frame("mid", 1'b0);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        reset_checks("mid_rst");
        @(negedge clk_div);
        reset = 1'b1;
        for (int f = 0; f < 3; f++) frame("mid_nopulse", 1'b0);
        frame("mid_pulse", 1'b1);
        chk("mid_code", {4'd0, key_code}, 8'h09);
        chk("mid_held", {7'd0, key_held}, 8'h01);
        tick();
        chk("mid_valid_drop", {7'd0, key_valid}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
